// File: rtl/dma_wb_mover.sv
// Wishbone B4 pipelined master that copies a block of 32-bit words from source to
// destination, one read then one write per word, under control of the DMA CSR block.
module dma_wb_mover #(
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [15:0] i_len,
    input  logic        i_go,
    input  logic        i_ie,
    input  logic        i_done_if,
    output logic        o_go_clr_en,
    output logic        o_go_clr_data,
    output logic        o_busy,
    output logic        o_done_set,
    output logic        o_xfer_err,
    output logic        o_irq,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_wb_stall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_e;

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [31:0]     src_q, src_d;
    logic [31:0]     dst_q, dst_d;
    logic [15:0]     rem_q, rem_d;
    logic [31:0]     buf_q, buf_d;
    logic            err_q, err_d;
    logic            go_clr_q, go_clr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            irq_q;
    logic            timed_out;

    // Timeout counts cycles already spent in the current wait state with no response.
    assign timed_out = (ACK_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        buf_d    = buf_q;
        err_d    = err_q;
        go_clr_d = 1'b0;
        tmo_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    src_d    = {i_src_addr[31:2], 2'b00};
                    dst_d    = {i_dst_addr[31:2], 2'b00};
                    rem_d    = i_len;
                    err_d    = 1'b0;
                    go_clr_d = 1'b1;
                    state_d  = (i_len == 16'd0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (!i_wb_stall) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_wb_err) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (i_wb_ack) begin
                    buf_d   = i_wb_dat;
                    state_d = S_WR_REQ;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_REQ: begin
                if (!i_wb_stall) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (i_wb_err) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (i_wb_ack) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? S_DONE : S_RD_REQ;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            buf_q    <= '0;
            err_q    <= 1'b0;
            go_clr_q <= 1'b0;
            tmo_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
            go_clr_q <= go_clr_d;
            tmo_q    <= tmo_d;
            irq_q    <= i_ie & i_done_if;
        end
    end

    // Bus and status outputs are decoded from registered state only.
    assign o_wb_cyc      = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                           (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
    assign o_wb_stb      = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign o_wb_we       = (state_q == S_WR_REQ);
    assign o_wb_adr      = (state_q == S_WR_REQ) ? dst_q :
                           (state_q == S_RD_REQ) ? src_q : 32'd0;
    assign o_wb_dat      = (state_q == S_WR_REQ) ? buf_q : 32'd0;
    assign o_wb_sel      = 4'hF;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done_set    = (state_q == S_DONE);
    assign o_xfer_err    = err_q;
    assign o_go_clr_en   = go_clr_q;
    assign o_go_clr_data = 1'b0;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_dma_wb_mover.sv
// Self-checking bench for dma_wb_mover: a Wishbone slave with configurable stall,
// ack latency, error and no-ack behaviour, plus a word-copy reference model.
module tb_dma_wb_mover;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_src_addr, i_dst_addr;
    logic [15:0] i_len;
    logic        i_go, i_ie, i_done_if;
    logic        o_go_clr_en, o_go_clr_data, o_busy, o_done_set, o_xfer_err, o_irq;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack, i_wb_err, i_wb_stall;

    always #5 i_clk = ~i_clk;

    dma_wb_mover #(.ACK_TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
        .i_go(i_go), .i_ie(i_ie), .i_done_if(i_done_if),
        .o_go_clr_en(o_go_clr_en), .o_go_clr_data(o_go_clr_data),
        .o_busy(o_busy), .o_done_set(o_done_set), .o_xfer_err(o_xfer_err), .o_irq(o_irq),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_stall(i_wb_stall)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [logic [31:0]];
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [31:0] rd_q[$];

    int cfg_stall     = 0;
    int cfg_ack_delay = 1;
    int cfg_err_read  = 0;
    bit cfg_no_ack    = 0;
    int rd_cnt        = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Reference: word i goes from aligned src + 4i to aligned dst + 4i (32-bit wrap).
    function automatic void build_model(input logic [31:0] src, input logic [31:0] dst,
                                        input int words);
        logic [31:0] s, d;
        exp_q.delete();
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        for (int i = 0; i < words; i++) begin
            exp_q.push_back({d, mem_rd(s)});
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endfunction

    function automatic void fill_mem(input logic [31:0] src, input int words);
        logic [31:0] s;
        s = src & 32'hFFFF_FFFC;
        for (int i = 0; i < words; i++) begin
            mem[s] = $urandom;
            s = s + 32'd4;
        end
    endfunction

    // Wishbone slave: responds at negedges so the DUT samples stable inputs at posedge.
    initial begin : slave
        bit          pending, pend_we, hold_valid, drop_chk;
        int          pend_idx, delay_left, stall_left;
        logic [31:0] pend_adr;
        logic [64:0] hold;
        pending = 0; hold_valid = 0; drop_chk = 0; stall_left = 0;
        delay_left = 0; pend_idx = 0; pend_we = 0; pend_adr = '0; hold = '0;
        i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0; i_wb_dat = '0;
        forever begin
            @(negedge i_clk);
            i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0; i_wb_dat = $urandom;
            if (i_rst || !o_wb_cyc) begin
                pending = 0; hold_valid = 0; drop_chk = 0; stall_left = cfg_stall;
                continue;
            end
            if (drop_chk) begin
                n_vec++;
                if (o_wb_stb !== 1'b0) begin
                    n_err++;
                    $display("FAIL stb_drop: stb=%b required 0 after acceptance", o_wb_stb);
                end
                drop_chk = 0;
            end
            if (hold_valid && o_wb_stb) begin
                n_vec++;
                if ({o_wb_we, o_wb_adr, o_wb_dat} !== hold) begin
                    n_err++;
                    $display("FAIL stall_hold: we/adr/dat=%h required %h",
                             {o_wb_we, o_wb_adr, o_wb_dat}, hold);
                end
            end
            hold_valid = 0;
            if (pending) begin
                if (!cfg_no_ack) begin
                    if (delay_left == 0) begin
                        pending = 0;
                        if (!pend_we && cfg_err_read == pend_idx) begin
                            i_wb_err = 1;
                        end else begin
                            i_wb_ack = 1;
                            if (!pend_we) i_wb_dat = mem_rd(pend_adr);
                        end
                    end else begin
                        delay_left--;
                    end
                end
            end else if (o_wb_stb) begin
                if (stall_left > 0) begin
                    i_wb_stall = 1;
                    stall_left--;
                    hold = {o_wb_we, o_wb_adr, o_wb_dat};
                    hold_valid = 1;
                end else begin
                    pending    = 1;
                    pend_we    = o_wb_we;
                    pend_adr   = o_wb_adr;
                    delay_left = cfg_ack_delay - 1;
                    drop_chk   = 1;
                    stall_left = cfg_stall;
                    if (o_wb_we) begin
                        wr_q.push_back({o_wb_adr, o_wb_dat});
                    end else begin
                        rd_cnt++;
                        pend_idx = rd_cnt;
                        rd_q.push_back(o_wb_adr);
                    end
                end
            end else begin
                stall_left = cfg_stall;
            end
        end
    end

    // Starts one transfer and watches it; cycle n=1 is the cycle right after the GO edge.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                            input bit keep_go, input int budget,
                            output int done_at, output int done_cnt, output int busy_fall,
                            output int goclr_at, output int goclr_cnt,
                            output bit cyc_ever, output bit cyc_in_done);
        wr_q.delete(); rd_q.delete(); rd_cnt = 0;
        done_at = -1; done_cnt = 0; busy_fall = -1; goclr_at = -1; goclr_cnt = 0;
        cyc_ever = 0; cyc_in_done = 0;
        @(negedge i_clk);
        i_src_addr = src; i_dst_addr = dst; i_len = len; i_go = 1'b1;
        @(posedge i_clk);
        for (int n = 1; n <= budget; n++) begin
            @(negedge i_clk);
            if (!keep_go) i_go = 1'b0;
            if (o_go_clr_en) begin
                goclr_cnt++;
                if (goclr_at < 0) goclr_at = n;
            end
            if (o_wb_cyc) cyc_ever = 1;
            if (o_done_set) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
                if (o_wb_cyc) cyc_in_done = 1;
            end
            if (!o_busy) begin
                busy_fall = n;
                break;
            end
        end
        if (busy_fall < 0) begin
            n_vec++; n_err++;
            $display("FAIL xfer_bound: busy still high after %0d cycles, required low", budget);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_go = 1'b0; i_ie = 1'b0; i_done_if = 1'b0;
        i_src_addr = '0; i_dst_addr = '0; i_len = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_vec++;
        if ({o_go_clr_en, o_go_clr_data, o_busy, o_done_set, o_xfer_err, o_irq,
             o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat} !== 73'd0) begin
            n_err++;
            $display("FAIL reset_outputs: %h required 0",
                     {o_go_clr_en, o_go_clr_data, o_busy, o_done_set, o_xfer_err, o_irq,
                      o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat});
        end
        n_vec++;
        if (o_wb_sel !== 4'hF) begin
            n_err++;
            $display("FAIL reset_sel: sel=%h required F", o_wb_sel);
        end
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        n_vec++;
        if ({o_busy, o_wb_cyc, o_go_clr_en} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_no_go: busy/cyc/goclr=%b required 000", {o_busy, o_wb_cyc, o_go_clr_en});
        end
    endtask

    task automatic test_zero_wait();
        int da, dc, bf, ga, gc;
        bit ce, cd;
        cfg_stall = 0; cfg_ack_delay = 1; cfg_err_read = 0; cfg_no_ack = 0;
        mem[32'h1000] = 32'hA0; mem[32'h1004] = 32'hA1; mem[32'h1008] = 32'hA2;
        build_model(32'h1000, 32'h2000, 3);
        run_xfer(32'h1000, 32'h2000, 16'd3, 0, 60, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (da !== 13 || dc !== 1) begin
            n_err++;
            $display("FAIL zw_done: done at %0d count %0d required 13 count 1", da, dc);
        end
        n_vec++;
        if (bf !== 14) begin
            n_err++;
            $display("FAIL zw_busy_fall: %0d required 14", bf);
        end
        n_vec++;
        if (ga !== 1 || gc !== 1) begin
            n_err++;
            $display("FAIL zw_go_clr: at %0d count %0d required at 1 count 1", ga, gc);
        end
        n_vec++;
        if (wr_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL zw_wr_count: %0d required %0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) begin
                n_vec++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL zw_write%0d: %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
        n_vec++;
        if (o_xfer_err !== 1'b0) begin
            n_err++;
            $display("FAIL zw_err: xfer_err=%b required 0", o_xfer_err);
        end
    endtask

    task automatic test_stall();
        int da, dc, bf, ga, gc;
        bit ce, cd;
        cfg_stall = 3; cfg_ack_delay = 2;
        fill_mem(32'hA000, 2);
        build_model(32'hA000, 32'hB000, 2);
        run_xfer(32'hA000, 32'hB000, 16'd2, 0, 100, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (da !== 25) begin
            n_err++;
            $display("FAIL stall_done: done at %0d required 25", da);
        end
        n_vec++;
        if (wr_q.size() !== 2) begin
            n_err++;
            $display("FAIL stall_wr_count: %0d required 2", wr_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) begin
                n_vec++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL stall_write%0d: %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
        cfg_stall = 0; cfg_ack_delay = 1;
    endtask

    task automatic test_bus_error();
        int da, dc, bf, ga, gc;
        bit ce, cd;
        cfg_err_read = 2;
        fill_mem(32'h5000, 4);
        build_model(32'h5000, 32'h6000, 1);
        run_xfer(32'h5000, 32'h6000, 16'd4, 0, 60, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (wr_q.size() !== 1 || rd_q.size() !== 2) begin
            n_err++;
            $display("FAIL err_bus_count: writes %0d reads %0d required 1 and 2", wr_q.size(), rd_q.size());
        end else begin
            n_vec++;
            if (wr_q[0] !== exp_q[0]) begin
                n_err++;
                $display("FAIL err_write0: %h required %h", wr_q[0], exp_q[0]);
            end
        end
        n_vec++;
        if (o_xfer_err !== 1'b1 || da !== 7 || dc !== 1 || cd !== 1'b0) begin
            n_err++;
            $display("FAIL err_abort: err=%b done_at=%0d cnt=%0d cyc_in_done=%b required 1/7/1/0",
                     o_xfer_err, da, dc, cd);
        end
        cfg_err_read = 0;
        run_xfer(32'h5000, 32'h6000, 16'd1, 0, 40, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (o_xfer_err !== 1'b0 || dc !== 1) begin
            n_err++;
            $display("FAIL err_cleared: err=%b done_cnt=%0d required 0 and 1", o_xfer_err, dc);
        end
    endtask

    task automatic test_len_zero();
        int da, dc, bf, ga, gc;
        bit ce, cd;
        run_xfer(32'h1000, 32'h2000, 16'd0, 0, 20, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (ce !== 1'b0 || da !== 1 || dc !== 1 || bf !== 2 || ga !== 1) begin
            n_err++;
            $display("FAIL len0: cyc=%b done_at=%0d cnt=%0d busy_fall=%0d goclr=%0d required 0/1/1/2/1",
                     ce, da, dc, bf, ga);
        end
        n_vec++;
        if (o_xfer_err !== 1'b0) begin
            n_err++;
            $display("FAIL len0_err: xfer_err=%b required 0", o_xfer_err);
        end
    endtask

    task automatic test_timeout_wrap();
        int da, dc, bf, ga, gc;
        bit ce, cd;
        cfg_no_ack = 1;
        run_xfer(32'h4000, 32'h4800, 16'd1, 0, 40, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (da !== 10 || o_xfer_err !== 1'b1 || wr_q.size() !== 0) begin
            n_err++;
            $display("FAIL timeout: done_at=%0d err=%b writes=%0d required 10/1/0",
                     da, o_xfer_err, wr_q.size());
        end
        cfg_no_ack = 0;
        fill_mem(32'hFFFF_FFFC, 1);
        fill_mem(32'h0000_0000, 1);
        build_model(32'hFFFF_FFFC, 32'h3000, 2);
        run_xfer(32'hFFFF_FFFC, 32'h3000, 16'd2, 0, 40, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (rd_q.size() !== 2 || wr_q.size() !== 2) begin
            n_err++;
            $display("FAIL wrap_count: reads %0d writes %0d required 2 and 2", rd_q.size(), wr_q.size());
        end else begin
            n_vec++;
            if (rd_q[1] !== 32'h0 || wr_q[1] !== exp_q[1]) begin
                n_err++;
                $display("FAIL wrap: read adr %h write %h required 0 and %h", rd_q[1], wr_q[1], exp_q[1]);
            end
        end
        fill_mem(32'h1000, 1);
        build_model(32'h1003, 32'h2006, 1);
        run_xfer(32'h1003, 32'h2006, 16'd1, 0, 40, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (rd_q.size() !== 1 || wr_q.size() !== 1) begin
            n_err++;
            $display("FAIL unaligned_count: reads %0d writes %0d required 1 and 1", rd_q.size(), wr_q.size());
        end else begin
            n_vec++;
            if (rd_q[0] !== 32'h1000 || wr_q[0] !== exp_q[0]) begin
                n_err++;
                $display("FAIL unaligned: read adr %h write %h required 1000 and %h", rd_q[0], wr_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_random();
        int da, dc, bf, ga, gc, words, exp_done;
        bit ce, cd;
        logic [31:0] src, dst;
        for (int k = 0; k < 5; k++) begin
            cfg_stall     = $urandom_range(0, 2);
            cfg_ack_delay = $urandom_range(1, 3);
            words         = $urandom_range(1, 5);
            src           = $urandom;
            dst           = $urandom;
            fill_mem(src, words);
            build_model(src, dst, words);
            exp_done = 1 + words * (2 + 2 * cfg_stall + 2 * cfg_ack_delay);
            run_xfer(src, dst, 16'(words), 0, 200, da, dc, bf, ga, gc, ce, cd);
            n_vec++;
            if (da !== exp_done || bf !== exp_done + 1) begin
                n_err++;
                $display("FAIL rand%0d_timing: done %0d fall %0d required %0d and %0d",
                         k, da, bf, exp_done, exp_done + 1);
            end
            n_vec++;
            if (wr_q.size() !== exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_count: %0d required %0d", k, wr_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                if (i < wr_q.size()) begin
                    n_vec++;
                    if (wr_q[i] !== exp_q[i]) begin
                        n_err++;
                        $display("FAIL rand%0d_write%0d: %h required %h", k, i, wr_q[i], exp_q[i]);
                    end
                end
            end
        end
        cfg_stall = 0; cfg_ack_delay = 1;
    endtask

    task automatic test_back_to_back();
        int da, dc, bf, ga, gc, fall2;
        bit ce, cd;
        fill_mem(32'hC000, 1);
        run_xfer(32'hC000, 32'hD000, 16'd1, 1, 40, da, dc, bf, ga, gc, ce, cd);
        n_vec++;
        if (da !== 5 || bf !== 6) begin
            n_err++;
            $display("FAIL b2b_first: done %0d fall %0d required 5 and 6", da, bf);
        end
        @(negedge i_clk);
        i_go = 1'b0;
        n_vec++;
        if (o_go_clr_en !== 1'b1 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_restart: goclr=%b busy=%b required 1 and 1", o_go_clr_en, o_busy);
        end
        fall2 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                fall2 = n;
                break;
            end
        end
        n_vec++;
        if (fall2 < 0 || wr_q.size() !== 2) begin
            n_err++;
            $display("FAIL b2b_second: idle_at=%0d writes=%0d required idle and 2", fall2, wr_q.size());
        end
    endtask

    task automatic test_go_busy_reset_irq();
        int  goclr_cnt, wr_waits, done_seen;
        bit  prev_wr_stb, hit;
        cfg_ack_delay = 3;
        fill_mem(32'h7000, 3);
        wr_q.delete(); rd_q.delete(); rd_cnt = 0;
        goclr_cnt = 0; wr_waits = 0; prev_wr_stb = 0; hit = 0; done_seen = 0;
        @(negedge i_clk);
        i_src_addr = 32'h7000; i_dst_addr = 32'h8000; i_len = 16'd3; i_go = 1'b1;
        @(posedge i_clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge i_clk);
            if (n == 2) i_src_addr = 32'h9000;
            if (o_go_clr_en) goclr_cnt++;
            if (o_done_set) done_seen++;
            if (prev_wr_stb && o_wb_cyc && !o_wb_stb) wr_waits++;
            prev_wr_stb = o_wb_stb && o_wb_we;
            if (wr_waits == 2) begin
                hit = 1;
                break;
            end
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL rst_reach_wrwait: second write wait not seen, required within 60 cycles");
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_go = 1'b0;
        n_vec++;
        if ({o_wb_cyc, o_wb_stb, o_busy, o_done_set} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid: cyc/stb/busy/done=%b required 0000", {o_wb_cyc, o_wb_stb, o_busy, o_done_set});
        end
        n_vec++;
        if (goclr_cnt !== 1 || rd_q.size() < 2 || rd_q[1] !== 32'h7004) begin
            n_err++;
            $display("FAIL go_ignored: goclr=%0d reads=%0d required 1 and second read at 7004",
                     goclr_cnt, rd_q.size());
        end
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge i_clk);
            if (o_done_set || o_busy || o_go_clr_en) done_seen++;
        end
        n_vec++;
        if (done_seen !== 0) begin
            n_err++;
            $display("FAIL rst_no_done: %0d done/busy/goclr events required 0", done_seen);
        end
        i_ie = 1'b1; i_done_if = 1'b1;
        #1;
        n_vec++;
        if (o_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_latency: irq=%b required 0 before the clock edge", o_irq);
        end
        @(negedge i_clk);
        n_vec++;
        if (o_irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_set: irq=%b required 1", o_irq);
        end
        i_ie = 1'b0;
        @(negedge i_clk);
        n_vec++;
        if (o_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_mask: irq=%b required 0", o_irq);
        end
        cfg_ack_delay = 1;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_bus_error();
        test_len_zero();
        test_timeout_wrap();
        test_random();
        test_back_to_back();
        test_go_busy_reset_irq();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
